// File: rtl/rx_intf_m_axis_pkt.sv
// -----------------------------------------------------------------------------
// rx_intf_m_axis_pkt
//
// Receive-side AXI-Stream master. Words from the rx accelerator are buffered
// in an internal first-word-fall-through FIFO. Each start_1trans pulse opens
// one packet of (M_AXIS_NUM_DMA_SYMBOL + 1) beats, closed with TLAST, toward
// the DMA S2MM port.
//
// Ports:
//   M_AXIS_ACLK / M_AXIS_ARESETN   clock, asynchronous active-low reset
//   DATA_FROM_ACC[_VALID]          accelerator write port
//   FULLN_TO_ACC                   FIFO can accept a word
//   data_count                     FIFO occupancy (0 .. 2^FIFO_ADDR_WIDTH)
//   M_AXIS_NUM_DMA_SYMBOL          beats per packet minus 1
//   start_1trans                   request one packet (honoured in IDLE only)
//   endless_mode                   suppress the beat-count TLAST
//   m_axis_busy                    packet open (SEND or DONE)
//   trans_done                     one-cycle pulse after the TLAST beat
//   overflow_cnt                   saturating count of dropped writes
//   M_AXIS_T*                      AXI-Stream master
//
// Build option:
//   RX_INTF_M_AXIS_PKT_OVERFLOW_CNT_EN  enables the overflow counter; when
//   undefined overflow_cnt is tied to zero.
// -----------------------------------------------------------------------------
module rx_intf_m_axis_pkt #(
    parameter int C_M_AXIS_TDATA_WIDTH   = 64,
    parameter int MAX_BIT_NUM_DMA_SYMBOL = 14,
    parameter int FIFO_ADDR_WIDTH        = 9
) (
    input  logic                                M_AXIS_ACLK,
    input  logic                                M_AXIS_ARESETN,

    input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     DATA_FROM_ACC,
    input  logic                                DATA_FROM_ACC_VALID,
    output logic                                FULLN_TO_ACC,
    output logic [FIFO_ADDR_WIDTH:0]            data_count,

    input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   M_AXIS_NUM_DMA_SYMBOL,
    input  logic                                start_1trans,
    input  logic                                endless_mode,
    output logic                                m_axis_busy,
    output logic                                trans_done,
    output logic [15:0]                         overflow_cnt,

    output logic                                M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
    output logic                                M_AXIS_TLAST,
    input  logic                                M_AXIS_TREADY
);

    localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
    localparam logic [FIFO_ADDR_WIDTH:0]          CNT_FULL = {1'b1, {FIFO_ADDR_WIDTH{1'b0}}};
    localparam logic [FIFO_ADDR_WIDTH:0]          CNT_ONE  = {{FIFO_ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [FIFO_ADDR_WIDTH-1:0]        PTR_ONE  = {{(FIFO_ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] BEAT_ONE = {{(MAX_BIT_NUM_DMA_SYMBOL-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [C_M_AXIS_TDATA_WIDTH-1:0]   mem [0:DEPTH-1];
    logic [FIFO_ADDR_WIDTH-1:0]        wr_ptr, rd_ptr;
    logic [FIFO_ADDR_WIDTH:0]          cnt_q;
    logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] beat_cnt, num_lat;

    logic fulln, not_empty, tvalid, tlast, wr_en, rd_en, pkt_open;

    // Full flag comes straight from the registered count, so a read on the
    // same edge does not make room for a write on that edge.
    assign fulln     = (cnt_q != CNT_FULL);
    assign not_empty = (cnt_q != '0);
    assign wr_en     = DATA_FROM_ACC_VALID && fulln;

    // TVALID depends only on async-reset registers, so it falls as soon as
    // reset asserts.
    assign tvalid   = (state == ST_SEND) && not_empty;
    assign rd_en    = tvalid && M_AXIS_TREADY;
    assign tlast    = tvalid && (beat_cnt == num_lat) && !endless_mode;
    assign pkt_open = (state == ST_IDLE) && start_1trans;

    // FIFO storage: no reset, head word read combinationally.
    always_ff @(posedge M_AXIS_ACLK) begin
        if (wr_en)
            mem[wr_ptr] <= DATA_FROM_ACC;
    end

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
            case ({wr_en, rd_en})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Packet FSM
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
            num_lat  <= '0;
        end else begin
            state <= state_nxt;
            if (pkt_open) begin
                num_lat  <= M_AXIS_NUM_DMA_SYMBOL;
                beat_cnt <= '0;
            end else if (rd_en) begin
                // Free-running wrap: in endless mode the count has no effect
                // until endless_mode drops and it comes round to num_lat.
                beat_cnt <= beat_cnt + BEAT_ONE;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_1trans)   state_nxt = ST_SEND;
            ST_SEND: if (rd_en && tlast) state_nxt = ST_DONE;
            ST_DONE:                     state_nxt = ST_IDLE;
            default:                     state_nxt = ST_IDLE;
        endcase
    end

`ifdef RX_INTF_M_AXIS_PKT_OVERFLOW_CNT_EN
    logic [15:0] ovf_q;

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN)
            ovf_q <= '0;
        else if (DATA_FROM_ACC_VALID && !fulln && (ovf_q != 16'hFFFF))
            ovf_q <= ovf_q + 16'd1;
    end

    assign overflow_cnt = ovf_q;
`else
    assign overflow_cnt = 16'd0;
`endif

    assign FULLN_TO_ACC  = fulln;
    assign data_count    = cnt_q;
    assign m_axis_busy   = (state != ST_IDLE);
    assign trans_done    = (state == ST_DONE);
    assign M_AXIS_TVALID = tvalid;
    // Gated so the bus reads zero whenever nothing is offered.
    assign M_AXIS_TDATA  = tvalid ? mem[rd_ptr] : '0;
    assign M_AXIS_TLAST  = tlast;
    assign M_AXIS_TSTRB  = '1;

endmodule

// File: tb/tb_rx_intf_m_axis_pkt.sv
module tb_rx_intf_m_axis_pkt;

    logic        clk, rst_n;
    logic [63:0] acc_data;
    logic        acc_valid, fulln;
    logic [9:0]  dcnt;
    logic [13:0] num;
    logic        start, endless, busy, done;
    logic [15:0] ovf;
    logic        tvalid, tlast, tready;
    logic [63:0] tdata;
    logic [7:0]  tstrb;

    rx_intf_m_axis_pkt dut (
        .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_n),
        .DATA_FROM_ACC(acc_data), .DATA_FROM_ACC_VALID(acc_valid),
        .FULLN_TO_ACC(fulln), .data_count(dcnt),
        .M_AXIS_NUM_DMA_SYMBOL(num), .start_1trans(start), .endless_mode(endless),
        .m_axis_busy(busy), .trans_done(done), .overflow_cnt(ovf),
        .M_AXIS_TVALID(tvalid), .M_AXIS_TDATA(tdata), .M_AXIS_TSTRB(tstrb),
        .M_AXIS_TLAST(tlast), .M_AXIS_TREADY(tready)
    );

`ifdef RX_INTF_M_AXIS_PKT_OVERFLOW_CNT_EN
    localparam logic [15:0] OVF_EXP = 16'd3;
`else
    localparam logic [15:0] OVF_EXP = 16'd0;
`endif

    typedef struct { logic [63:0] d; logic l; } exp_t;
    exp_t sb[$];

    int n_cmp = 0, n_err = 0, done_cnt = 0;
    int rdy_mode = 0;  // 0: ready high, 1: toggle, 2: ready low

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [63:0] d, input logic l);
        exp_t e;
        e.d = d; e.l = l;
        sb.push_back(e);
    endtask

    // Scoreboard monitor: every handshake pops one expected beat; a stall
    // must hold TVALID/TDATA/TLAST on the following cycle.
    task automatic monitor();
        logic [63:0] pd = '0;
        logic        pl = 1'b0;
        bit          pstall = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pstall = 1'b0;
            end else begin
                if (pstall) begin
                    chk("stall_valid", 64'(tvalid), 64'd1);
                    if (tvalid) begin
                        chk("stall_data", tdata, pd);
                        chk("stall_last", 64'(tlast), 64'(pl));
                    end
                end
                if (tvalid && tready) begin
                    if (sb.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL beat_unexpected: got data %0h with nothing expected", tdata);
                    end else begin
                        e = sb.pop_front();
                        chk("beat_data", tdata, e.d);
                        chk("beat_last", 64'(tlast), 64'(e.l));
                    end
                end
                pstall = tvalid && !tready;
                pd = tdata;
                pl = tlast;
                if (done) done_cnt++;
            end
        end
    endtask

    task automatic ready_drv();
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       tready = 1'b1;
                1:       tready = ~tready;
                default: tready = 1'b0;
            endcase
        end
    endtask

    task automatic write_words(input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            acc_valid = 1'b1;
            acc_data  = base + 64'(i);
        end
        @(posedge clk); #1;
        acc_valid = 1'b0;
    endtask

    task automatic start_pkt(input logic [13:0] n);
        @(posedge clk); #1;
        num = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_last(input int bound, output int cyc);
        cyc = 0;
        for (int c = 1; c <= bound; c++) begin
            @(negedge clk);
            if (tvalid && tready && tlast) begin
                cyc = c;
                break;
            end
        end
        if (cyc == 0) begin
            n_cmp++; n_err++;
            $display("FAIL wait_last: no TLAST handshake within %0d cycles", bound);
        end
    endtask

    // Called at the negedge of the TLAST handshake.
    task automatic check_close(input string tag);
        @(negedge clk);
        chk({tag, "_done_hi"}, 64'(done), 64'd1);
        chk({tag, "_busy_done"}, 64'(busy), 64'd1);
        @(negedge clk);
        chk({tag, "_done_lo"}, 64'(done), 64'd0);
        chk({tag, "_busy_lo"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int cyc, d0;
        rst_n = 1'b0; acc_data = '0; acc_valid = 1'b0; num = '0;
        start = 1'b0; endless = 1'b0; tready = 1'b1;
        fork
            monitor();
            ready_drv();
        join_none

        // Reset values
        repeat (3) @(posedge clk);
        #2;
        chk("rst_tvalid", 64'(tvalid), 64'd0);
        chk("rst_tlast", 64'(tlast), 64'd0);
        chk("rst_tdata", tdata, 64'd0);
        chk("rst_fulln", 64'(fulln), 64'd1);
        chk("rst_dcnt", 64'(dcnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("tstrb", 64'(tstrb), 64'hFF);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single packet: 4 back-to-back beats, TLAST on the 4th
        write_words(64'hA0, 4);
        chk("t1_dcnt", 64'(dcnt), 64'd4);
        chk("t1_idle_valid", 64'(tvalid), 64'd0);
        for (int i = 0; i < 4; i++) push(64'hA0 + 64'(i), i == 3);
        start_pkt(14'd3);
        wait_last(20, cyc);
        chk("t1_latency", 64'(cyc), 64'd4);
        check_close("t1");

        // Backpressure: ready toggles every cycle
        write_words(64'hB0, 8);
        for (int i = 0; i < 8; i++) push(64'hB0 + 64'(i), i == 7);
        rdy_mode = 1;
        start_pkt(14'd7);
        wait_last(40, cyc);
        check_close("t2");
        chk("t2_dcnt", 64'(dcnt), 64'd0);
        rdy_mode = 0;

        // Full / overflow: 515 writes into an idle block
        for (int i = 0; i < 515; i++) begin
            @(posedge clk); #1;
            acc_valid = 1'b1;
            acc_data  = 64'h1000 + 64'(i);
            if (i == 511) chk("t3_fulln_511", 64'(fulln), 64'd1);
            if (i == 512) chk("t3_fulln_512", 64'(fulln), 64'd0);
        end
        @(posedge clk); #1;
        acc_valid = 1'b0;
        chk("t3_dcnt_full", 64'(dcnt), 64'd512);
        chk("t3_fulln", 64'(fulln), 64'd0);
        chk("t3_ovf", 64'(ovf), 64'(OVF_EXP));
        for (int i = 0; i < 512; i++) push(64'h1000 + 64'(i), i == 511);
        start_pkt(14'd511);
        wait_last(600, cyc);
        check_close("t3");
        chk("t3_dcnt_empty", 64'(dcnt), 64'd0);
        chk("t3_fulln_after", 64'(fulln), 64'd1);
        chk("t3_ovf_hold", 64'(ovf), 64'(OVF_EXP));

        // Endless, NUM=2: first 10+ beats carry no TLAST; endless drops after
        // beat_cnt passed 2, so TLAST waits for the wrap (beat 16384+2).
        endless = 1'b1;
        start_pkt(14'd2);
        for (int i = 0; i < 16387; i++) begin
            @(posedge clk); #1;
            acc_valid = 1'b1;
            acc_data  = 64'h5000_0000 + 64'(i);
            push(64'h5000_0000 + 64'(i), i == 16386);
            if (i == 12) endless = 1'b0;
        end
        @(posedge clk); #1;
        acc_valid = 1'b0;
        wait_last(10, cyc);
        check_close("t4w");

        // Endless drops when beat_cnt=1: TLAST on the beat with beat_cnt=2
        endless = 1'b1;
        write_words(64'hD0, 1);
        push(64'hD0, 1'b0);
        start_pkt(14'd2);
        @(posedge clk); #1;
        endless = 1'b0;
        push(64'hD1, 1'b0);
        push(64'hD2, 1'b1);
        write_words(64'hD1, 2);
        wait_last(10, cyc);
        check_close("t4d");

        // Reset during beat 5 of a 16-beat packet
        write_words(64'hE0, 16);
        for (int i = 0; i < 16; i++) push(64'hE0 + 64'(i), i == 15);
        start_pkt(14'd15);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_tvalid", 64'(tvalid), 64'd0);
        chk("t5_rst_dcnt", 64'(dcnt), 64'd0);
        chk("t5_rst_busy", 64'(busy), 64'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        write_words(64'hF0, 2);
        push(64'hF0, 1'b0);
        push(64'hF1, 1'b1);
        start_pkt(14'd1);
        wait_last(10, cyc);
        check_close("t5");

        // Second start while in SEND is ignored (and must not relatch NUM)
        write_words(64'hC0, 4);
        for (int i = 0; i < 4; i++) push(64'hC0 + 64'(i), i == 3);
        rdy_mode = 2;
        start_pkt(14'd3);
        d0 = done_cnt;
        repeat (2) @(posedge clk);
        start_pkt(14'd1);
        chk("t6_busy", 64'(busy), 64'd1);
        rdy_mode = 0;
        wait_last(20, cyc);
        repeat (6) @(negedge clk);
        chk("t6_done_once", 64'(done_cnt - d0), 64'd1);
        chk("t6_busy_lo", 64'(busy), 64'd0);
        chk("t6_valid_lo", 64'(tvalid), 64'd0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
